regfile_bypass: RTL and testbench



---
 rtl/regfile_bypass.sv | 81 ++++++++
 tb/tb_regfile_bypass.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// regfile_bypass: 32 x 64-bit LEGv8 architectural register file.
// Two combinational read ports with same-cycle writeback bypass, one
// synchronous write port, and a hardwired zero register (XZR).
module regfile_bypass #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   input  logic [ADDR_WIDTH-1:0] WriteRegister,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_REG);

   logic [DEPTH-1:0]      wen;
   logic [DATA_WIDTH-1:0] entry [DEPTH];
   logic                  byp_ok;

   // Resolve one read port: zero register first, then bypass, then storage.
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic                  bypass_en,
      input logic [ADDR_WIDTH-1:0] widx,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (idx == ZIDX)
         return '0;
      else if (bypass_en && (widx == idx))
         return wdata;
      else
         return stored;
   endfunction

   // Bypass only for a real write that will land this edge (not under reset).
   assign byp_ok = RegWrite && !reset && (WriteRegister != ZIDX);

   // Write-enable decoder: one-hot, or all-zero for no write / writes to XZR.
   always_comb begin
      wen = '0;
      if (RegWrite && (WriteRegister != ZIDX))
         wen[WriteRegister] = 1'b1;
   end

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_entry
         if (i == ZERO_REG) begin : g_zero
            // XZR has no storage; it always presents zero.
            assign entry[i] = '0;
         end else begin : g_reg
            logic [DATA_WIDTH-1:0] q;
            // Per-entry register: reset clears it and wins over a write.
            always_ff @(posedge clk) begin
               if (reset)
                  q <= '0;
               else if (wen[i])
                  q <= WriteData;
            end
            assign entry[i] = q;
         end
      end
   endgenerate

   // Two independent combinational read muxes with bypass.
   always_comb begin
      ReadData1 = read_port(ReadRegister1, byp_ok, WriteRegister, WriteData,
                            entry[ReadRegister1]);
      ReadData2 = read_port(ReadRegister2, byp_ok, WriteRegister, WriteData,
                            entry[ReadRegister2]);
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: directed scenarios plus a random
// run, scored against an array model of the register file.
module tb_regfile_bypass;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
   logic [63:0] WriteData;
   logic        RegWrite;
   logic [63:0] ReadData1, ReadData2;

   regfile_bypass dut (
      .clk           (clk),
      .reset         (reset),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [63:0] e1;
      logic [63:0] e2;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] model [32];
   int          vectors = 0;
   int          errors  = 0;
   bit          rst_seen = 0;

   // Expected value of one read port, from the architectural rules.
   function automatic logic [63:0] expect_read(input logic [4:0] idx,
                                               input bit rst, input bit we,
                                               input logic [4:0] wr,
                                               input logic [63:0] wd);
      if (idx == 5'd31) return 64'd0;
      if (we && !rst && wr == idx) return wd;
      return model[idx];
   endfunction

   // Drive one cycle (called at posedge+1), queue the expectation, then
   // advance the model across the clock edge.
   task automatic apply(input bit rst, input bit we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [4:0] r1,
                        input logic [4:0] r2);
      exp_t it;
      reset = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
      ReadRegister1 = r1; ReadRegister2 = r2;
      it.a1 = r1; it.a2 = r2;
      it.e1 = expect_read(r1, rst, we, wr, wd);
      it.e2 = expect_read(r2, rst, we, wr, wd);
      sbq.push_back(it);
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 32; k++) model[k] = 64'd0;
      end else if (we && wr != 5'd31) begin
         model[wr] = wd;
      end
      #1;
   endtask

   task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
      apply(1'b0, 1'b0, 5'd0, 64'd0, r1, r2);
   endtask

   // Monitor: read ports are combinational, so check mid-cycle.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t it;
         it = sbq.pop_front();
         vectors++;
         if (ReadData1 !== it.e1) begin
            errors++;
            $display("FAIL rd1 idx=%0d got=%h want=%h t=%0t", it.a1, ReadData1, it.e1, $time);
         end
         vectors++;
         if (ReadData2 !== it.e2) begin
            errors++;
            $display("FAIL rd2 idx=%0d got=%h want=%h t=%0t", it.a2, ReadData2, it.e2, $time);
         end
      end
   end

   // RegWrite must never be unknown once reset has been seen.
   always @(posedge clk) begin
      if (rst_seen && $isunknown(RegWrite)) begin
         errors++;
         $display("FAIL regwrite_x got=%b want=0/1 t=%0t", RegWrite, $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0]  wr, r1, r2;
      logic [63:0] wd;
      bit          we, rst;

      reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_seen = 1;
      for (int k = 0; k < 32; k++) model[k] = 64'd0;

      // Reset then sweep all indices on both ports.
      apply(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd31);
      for (int k = 0; k < 32; k++) rd(5'(k), 5'(31 - k));

      // Write/readback, neighbours untouched.
      apply(1'b0, 1'b1, 5'd5,  64'hDEADBEEF_01234567, 5'd5, 5'd30);
      apply(1'b0, 1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd30);
      rd(5'd5, 5'd30);
      rd(5'd4, 5'd6);

      // Zero register ignores writes and never bypasses.
      apply(1'b0, 1'b1, 5'd31, 64'h1234, 5'd31, 5'd5);
      rd(5'd31, 5'd30);

      // Bypass on both ports.
      apply(1'b0, 1'b1, 5'd7, 64'h10, 5'd0, 5'd1);
      rd(5'd7, 5'd7);
      apply(1'b0, 1'b1, 5'd7, 64'h99, 5'd7, 5'd7);
      rd(5'd7, 5'd7);

      // Reset beats a simultaneous write; no bypass during reset.
      apply(1'b0, 1'b1, 5'd3, 64'h55, 5'd0, 5'd0);
      apply(1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd7);
      rd(5'd3, 5'd7);

      // Random traffic with biased bypass and occasional reset.
      for (int n = 0; n < 2000; n++) begin
         wr  = 5'($urandom_range(0, 31));
         wd  = {$urandom, $urandom};
         we  = $urandom_range(0, 1) == 1;
         rst = $urandom_range(0, 99) == 0;
         r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         apply(rst, we, wr, wd, r1, r2);
      end

      @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d want=0 pending", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
